branch_sequencer: RTL and testbench

Cycle-accurate sequencer for the 6502 relative-branch instructions (BPL/BMI/BVC/BVS/BCC/BCS/BNE/BEQ). It sits directly downstream of instruction decode and drives the team's combinational branch target calculator. It fetches the offset byte, snapshots the status register, and feeds the calculator. It then consumes the calculator's taken/target/page-cross results to load the new PC with exact 2/3/4-cycle timing, including the 6502 dummy reads.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_sequencer.sv | 141 ++++++++++++++
 tb/tb_branch_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the 6502 relative-branch sequencer.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_OFF = 2'd1,
    TAKEN     = 2'd2,
    FIXUP     = 2'd3
  } bseq_state_t;

  // Relative-branch opcodes (all of the form xxx1_0000).
  localparam logic [7:0] OP_BPL = 8'h10;
  localparam logic [7:0] OP_BMI = 8'h30;
  localparam logic [7:0] OP_BVC = 8'h50;
  localparam logic [7:0] OP_BVS = 8'h70;
  localparam logic [7:0] OP_BCC = 8'h90;
  localparam logic [7:0] OP_BCS = 8'hB0;
  localparam logic [7:0] OP_BNE = 8'hD0;
  localparam logic [7:0] OP_BEQ = 8'hF0;

  // Total instruction cycle counts: not taken, taken, taken across a page.
  localparam logic [2:0] BR_CYC_NT = 3'd2;
  localparam logic [2:0] BR_CYC_T  = 3'd3;
  localparam logic [2:0] BR_CYC_TX = 3'd4;

endpackage

// File: rtl/branch_sequencer.sv
// Cycle-accurate 2/3/4-cycle sequencer for 6502 relative branches. Fetches
// the offset byte, drives the external target calculator and loads the PC,
// issuing the same dummy reads as the original part.
module branch_sequencer
  import branch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  opcode_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  status_in,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [7:0]  calc_opcode,
  output logic [7:0]  calc_offset,
  output logic [15:0] calc_pc,
  output logic [7:0]  calc_status,
  input  logic [15:0] calc_target,
  input  logic        calc_taken,
  input  logic        calc_page_crossed,
  output logic        pc_load,
  output logic [15:0] pc_next,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  cycles
);

  bseq_state_t state, state_nx;
  logic [7:0]  op_q, st_q, off_q;
  logic [15:0] pc_q, tgt_q, pc_next_q, pc_nx, pc_fall;
  logic        cross_q, is_branch;
  logic [2:0]  cycles_q, cycles_nx;

  assign is_branch = op_q inside {OP_BPL, OP_BMI, OP_BVC, OP_BVS,
                                  OP_BCC, OP_BCS, OP_BNE, OP_BEQ};
  assign pc_fall   = pc_q + 16'd2;

  assign calc_opcode = op_q;
  assign calc_pc     = pc_q;
  assign calc_status = st_q;
  assign busy        = (state != IDLE);
  // The held values are bypassed so the new PC/cycle count is visible in
  // the same cycle that pc_load/done pulse.
  assign pc_next     = pc_nx;
  assign cycles      = cycles_nx;

  // Per-state bus activity, completion decision and next state.
  always_comb begin
    state_nx    = state;
    mem_rd      = 1'b0;
    mem_addr    = 16'h0000;
    calc_offset = off_q;
    pc_load     = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    pc_nx       = pc_next_q;
    cycles_nx   = cycles_q;
    case (state)
      IDLE: begin
        if (start) state_nx = FETCH_OFF;
      end
      FETCH_OFF: begin
        mem_rd      = 1'b1;
        mem_addr    = pc_q + 16'd1;
        // The calculator sees the offset byte in the cycle it is read.
        calc_offset = mem_rdata;
        if (!is_branch) begin
          err       = 1'b1;
          done      = 1'b1;
          cycles_nx = BR_CYC_NT;
          state_nx  = IDLE;
        end else if (!calc_taken) begin
          pc_load   = 1'b1;
          pc_nx     = pc_fall;
          done      = 1'b1;
          cycles_nx = BR_CYC_NT;
          state_nx  = IDLE;
        end else begin
          state_nx  = TAKEN;
        end
      end
      TAKEN: begin
        mem_rd   = 1'b1;
        mem_addr = pc_fall;
        if (!cross_q) begin
          pc_load   = 1'b1;
          pc_nx     = tgt_q;
          done      = 1'b1;
          cycles_nx = BR_CYC_T;
          state_nx  = IDLE;
        end else begin
          state_nx  = FIXUP;
        end
      end
      FIXUP: begin
        // Dummy read with the uncorrected high byte, as the real 6502 does.
        mem_rd    = 1'b1;
        mem_addr  = {pc_fall[15:8], tgt_q[7:0]};
        pc_load   = 1'b1;
        pc_nx     = tgt_q;
        done      = 1'b1;
        cycles_nx = BR_CYC_TX;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register plus instruction context and held results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 8'h00;
      pc_q      <= 16'h0000;
      st_q      <= 8'h00;
      off_q     <= 8'h00;
      tgt_q     <= 16'h0000;
      cross_q   <= 1'b0;
      pc_next_q <= 16'h0000;
      cycles_q  <= 3'd0;
    end else begin
      state     <= state_nx;
      pc_next_q <= pc_nx;
      cycles_q  <= cycles_nx;
      if (state == IDLE && start) begin
        op_q <= opcode_in;
        pc_q <= pc_in;
        st_q <= status_in;
      end
      if (state == FETCH_OFF) begin
        off_q   <= mem_rdata;
        tgt_q   <= calc_target;
        cross_q <= calc_page_crossed;
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: behavioural memory and branch
// calculator around the DUT, expectations from a per-instruction model.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  opcode_in, status_in, mem_rdata;
  logic [15:0] pc_in, mem_addr;
  logic        mem_rd;
  logic [7:0]  calc_opcode, calc_offset, calc_status;
  logic [15:0] calc_pc, calc_target;
  logic        calc_taken, calc_page_crossed;
  logic        pc_load, busy, done, err;
  logic [15:0] pc_next;
  logic [2:0]  cycles;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_pc_next;
  logic [2:0]  exp_cycles;

  logic [7:0] mem [65536];

  always #5 clk = ~clk;

  branch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode_in(opcode_in),
    .pc_in(pc_in), .status_in(status_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .calc_opcode(calc_opcode),
    .calc_offset(calc_offset), .calc_pc(calc_pc), .calc_status(calc_status),
    .calc_target(calc_target), .calc_taken(calc_taken),
    .calc_page_crossed(calc_page_crossed), .pc_load(pc_load),
    .pc_next(pc_next), .busy(busy), .done(done), .err(err), .cycles(cycles)
  );

  assign mem_rdata = mem[mem_addr];

  // Branch condition from the 6502 opcode table.
  function automatic logic cond_taken(input logic [7:0] op, input logic [7:0] st);
    case (op)
      8'h10: return !st[7];
      8'h30: return  st[7];
      8'h50: return !st[6];
      8'h70: return  st[6];
      8'h90: return !st[0];
      8'hB0: return  st[0];
      8'hD0: return !st[1];
      8'hF0: return  st[1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] rel_target(input logic [15:0] pc, input logic [7:0] off);
    int soff;
    int t;
    soff = int'(off);
    if (soff > 127) soff = soff - 256;
    t = int'(pc) + 2 + soff;
    return t[15:0];
  endfunction

  // Combinational branch target calculator the CPU places beside the DUT.
  always_comb begin
    calc_target       = rel_target(calc_pc, calc_offset);
    calc_taken        = cond_taken(calc_opcode, calc_status);
    calc_page_crossed = (calc_target[15:8] != 8'((int'(calc_pc) + 2) >> 8));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One branch, started in the cycle after the previous one finished.
  task automatic run_br(input string tag, input logic [7:0] op, input logic [15:0] pc,
                        input logic [7:0] st, input logic [7:0] off);
    logic [15:0] fall, tgt;
    logic [15:0] rd [3];
    logic br, tk, cr, last;
    int n;
    fall = 16'((int'(pc) + 2) % 65536);
    tgt  = rel_target(pc, off);
    br   = ((op & 8'h1F) == 8'h10);
    tk   = br && cond_taken(op, st);
    cr   = (tgt[15:8] != fall[15:8]);
    n    = !tk ? 2 : (!cr ? 3 : 4);
    rd[0] = 16'((int'(pc) + 1) % 65536);
    rd[1] = fall;
    rd[2] = {fall[15:8], tgt[7:0]};

    @(negedge clk);
    start = 1'b1; opcode_in = op; pc_in = pc; status_in = st;
    mem[rd[0]] = off;
    #1;
    chk({tag, ":idle_busy"}, busy, 0);
    chk({tag, ":idle_done"}, done, 0);
    chk({tag, ":idle_pcload"}, pc_load, 0);
    chk({tag, ":idle_rd"}, mem_rd, 0);
    chk({tag, ":held_pc_next"}, pc_next, exp_pc_next);
    chk({tag, ":held_cycles"}, cycles, exp_cycles);

    for (int c = 2; c <= n; c++) begin
      @(negedge clk);
      // Junk on the start interface must be ignored while busy.
      start = 1'b1; opcode_in = 8'($urandom); pc_in = 16'($urandom);
      status_in = 8'($urandom);
      #1;
      last = (c == n);
      chk($sformatf("%s:c%0d_busy", tag, c), busy, 1);
      chk($sformatf("%s:c%0d_rd", tag, c), mem_rd, 1);
      chk($sformatf("%s:c%0d_addr", tag, c), mem_addr, rd[c-2]);
      chk($sformatf("%s:c%0d_done", tag, c), done, last);
      chk($sformatf("%s:c%0d_pcload", tag, c), pc_load, last && br);
      chk($sformatf("%s:c%0d_err", tag, c), err, last && !br);
      if (c == 2) begin
        chk({tag, ":calc_pc"}, calc_pc, pc);
        chk({tag, ":calc_op"}, calc_opcode, op);
        chk({tag, ":calc_st"}, calc_status, st);
        chk({tag, ":calc_off"}, calc_offset, off);
      end
      if (last) begin
        if (br) exp_pc_next = tk ? tgt : fall;
        exp_cycles = 3'(n);
        chk({tag, ":pc_next"}, pc_next, exp_pc_next);
        chk({tag, ":cycles"}, cycles, exp_cycles);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] br_ops [8];
    logic [7:0] op;
    br_ops = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1; start = 1'b0; opcode_in = 8'h00; pc_in = 16'h0000; status_in = 8'h00;
    exp_pc_next = 16'h0000; exp_cycles = 3'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc_next", pc_next, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_calc_pc", calc_pc, 0);
    rst = 1'b0;

    run_br("bne_taken",  8'hD0, 16'h0200, 8'h00, 8'h10);
    run_br("beq_nt",     8'hF0, 16'h0200, 8'h00, 8'h10);
    run_br("bcs_cross",  8'hB0, 16'h02F0, 8'h01, 8'h20);
    run_br("bpl_back",   8'h10, 16'h0300, 8'h00, 8'hFC);
    run_br("bvs_wrap",   8'h70, 16'hFFFE, 8'h40, 8'h05);
    run_br("err_ea",     8'hEA, 16'h1234, 8'h00, 8'h33);
    run_br("bpl_ffff",   8'h10, 16'hFFFF, 8'h00, 8'h00);
    run_br("bmi_under",  8'h30, 16'h0000, 8'h80, 8'h80);

    // Reset while in TAKEN: no PC load, everything cleared.
    @(negedge clk);
    start = 1'b1; opcode_in = 8'hD0; pc_in = 16'h0200; status_in = 8'h00;
    mem[16'h0201] = 8'h10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("rs_taken_addr", mem_addr, 16'h0202);
    rst = 1'b1;
    #1;
    chk("rs_rd", mem_rd, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_pcload", pc_load, 0);
    chk("rs_pc_next", pc_next, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_err", err, 0);
    chk("rs_cycles", cycles, 0);
    chk("rs_calc", {calc_opcode, calc_offset, calc_status}, 0);
    chk("rs_calc_pc", calc_pc, 0);
    @(posedge clk);
    #1;
    chk("rs_pcload2", pc_load, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_pc_next = 16'h0000; exp_cycles = 3'd0;

    run_br("after_rst", 8'hD0, 16'h0200, 8'h00, 8'h10);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) op = 8'($urandom);
      else op = br_ops[$urandom_range(0, 7)];
      run_br($sformatf("rnd%0d", k), op, 16'($urandom), 8'($urandom), 8'($urandom));
    end

    @(negedge clk);
    #1;
    chk("final_busy", busy, 0);
    chk("final_pc_next", pc_next, exp_pc_next);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
